// File: rtl/uart_tx_module.sv
// uart_tx_module: UART transmitter, one 8-bit byte per request as start + 8 data (LSB first) + STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx_module #(
  parameter int unsigned BAUD_DIV  = 5208,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       Tx_En_Sig,
  input  logic [7:0] Tx_Data,
  output logic       Tx_Done_Sig,
  output logic       Tx_Busy,
  output logic       TX_Pin_Out
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned IDX_W = 3;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              pin_q, pin_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              bit_end;
  logic [IDX_W-1:0]  idx_nxt;

  // State and output registers; reset abandons any frame and drives the line high.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      pin_q   <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      pin_q   <= pin_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so they leave the registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pin_d   = pin_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    bit_end = (cnt_q == CNT_W'(BAUD_DIV - 1));
    idx_nxt = idx_q + 1'b1;

    if (state_q != S_IDLE && state_q != S_DONE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        pin_d  = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (Tx_En_Sig) begin
          shift_d = Tx_Data;
          busy_d  = 1'b1;
          pin_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          pin_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(7)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            pin_d   = ^shift_q;
`else
            state_d = S_STOP;
            pin_d   = 1'b1;
`endif
          end else begin
            idx_d = idx_nxt;
            pin_d = shift_q[idx_nxt];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          pin_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        pin_d = 1'b1;
        // bit index is reused to count stop bits
        if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        pin_d   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        pin_d   = 1'b1;
      end
    endcase
  end

  assign Tx_Done_Sig = done_q;
  assign Tx_Busy     = busy_q;
  assign TX_Pin_Out  = pin_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// tb_uart_tx_module: scoreboard bench; expected line levels are queued per request and checked every cycle.
module tb_uart_tx_module;

  localparam int unsigned BD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en1   = 1'b0;
  logic       en2   = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       done1, busy1, pin1;
  logic       done2, busy2, pin2;

  bit   sel = 1'b0;
  bit   exp_q[$];
  int   total = 0;
  int   bad   = 0;

  uart_tx_module #(.BAUD_DIV(BD), .STOP_BITS(1)) dut (
    .CLK(clk), .RST_n(rst_n), .Tx_En_Sig(en1), .Tx_Data(data),
    .Tx_Done_Sig(done1), .Tx_Busy(busy1), .TX_Pin_Out(pin1)
  );

  uart_tx_module #(.BAUD_DIV(BD), .STOP_BITS(2)) dut2 (
    .CLK(clk), .RST_n(rst_n), .Tx_En_Sig(en2), .Tx_Data(data),
    .Tx_Done_Sig(done2), .Tx_Busy(busy2), .TX_Pin_Out(pin2)
  );

  always #5 clk = ~clk;

  function automatic logic obs_pin();  return sel ? pin2  : pin1;  endfunction
  function automatic logic obs_busy(); return sel ? busy2 : busy1; endfunction
  function automatic logic obs_done(); return sel ? done2 : done1; endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: start, data LSB first, optional even parity, stop bits of the selected DUT.
  task automatic push_frame(input logic [7:0] d);
    int stops;
    stops = sel ? 2 : 1;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  task automatic request(input logic [7:0] d);
    data = d;
    if (sel) en2 = 1'b1; else en1 = 1'b1;
    push_frame(d);
    tick();
  endtask

  task automatic check_frame(input bit hold, input bit chain, input bit glitch);
    int c;
    bit b;
    c = 0;
    if (!hold) begin en1 = 1'b0; en2 = 1'b0; end
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      for (int k = 0; k < int'(BD); k++) begin
        if (glitch && c == 10) begin
          data = 8'hFF;
          if (sel) en2 = 1'b1; else en1 = 1'b1;
        end
        if (glitch && c == 11) begin en1 = 1'b0; en2 = 1'b0; end
        chk("line", obs_pin(), b);
        chk("busy_frame", obs_busy(), 1'b1);
        chk("done_early", obs_done(), 1'b0);
        c++;
        tick();
      end
    end
    chk("done_pulse", obs_done(), 1'b1);
    chk("busy_done", obs_busy(), 1'b1);
    chk("line_done", obs_pin(), 1'b1);
    if (!chain) begin en1 = 1'b0; en2 = 1'b0; end
    tick();
    chk("done_clear", obs_done(), 1'b0);
    chk("busy_clear", obs_busy(), 1'b0);
    chk("line_idle", obs_pin(), 1'b1);
  endtask

  initial begin
    // reset held, then released with no request
    tick();
    chk("rst_line", pin1, 1'b1);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_line", pin1, 1'b1);
      chk("idle_busy", busy1, 1'b0);
      chk("idle_done", done1, 1'b0);
      chk("idle_line2", pin2, 1'b1);
    end

    // 0x55 single frame
    sel = 1'b0;
    request(8'h55);
    check_frame(1'b0, 1'b0, 1'b0);

    // 0xA3 with an ignored 0xFF request mid-frame
    request(8'hA3);
    check_frame(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("no_queue_line", pin1, 1'b1);
      chk("no_queue_busy", busy1, 1'b0);
    end

    // parity-sensitive patterns
    request(8'h07);
    check_frame(1'b0, 1'b0, 1'b0);
    request(8'h03);
    check_frame(1'b0, 1'b0, 1'b0);

    // back-to-back frames with two stop bits and request held high
    sel = 1'b1;
    request(8'h00);
    check_frame(1'b1, 1'b1, 1'b0);
    request(8'h00);
    check_frame(1'b1, 1'b1, 1'b0);
    request(8'h00);
    check_frame(1'b1, 1'b0, 1'b0);
    tick();
    chk("chain_stop_busy", busy2, 1'b0);

    // reset during data bit 3 of 0x0F
    sel = 1'b0;
    request(8'h0F);
    en1 = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 17; i++) tick();
    chk("pre_rst_busy", busy1, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_line", pin1, 1'b1);
    chk("async_rst_busy", busy1, 1'b0);
    chk("async_rst_done", done1, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_done", done1, 1'b0);
      chk("post_rst_line", pin1, 1'b1);
    end
    request(8'h0F);
    check_frame(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
